apb4_master_bridge: RTL and testbench
=====================================

Name: apb4_master_bridge

Overview:
- Single-outstanding APB4 initiator: converts a valid/ready command stream into compliant APB4 SETUP/ACCESS transfers and returns each completion on a valid/ready response stream.
- Drives the master side of an apb4_if-compatible bus toward peripheral slaves such as apb4_timer.
- Replaces hand-written bus-driving tasks with synthesizable RTL in benches and SoC glue.
- Includes a PREADY timeout, so a hung slave cannot stall the initiator.

Parameters:
- ADDR_WIDTH, 32, width of paddr_o and cmd_addr_i
- DATA_WIDTH, 32, width of write/read data; must be a multiple of 8
- TIMEOUT, 255, ACCESS cycles with pready low before forced error termination; 0 disables the timeout
- CNT_WIDTH, $clog2(TIMEOUT+1) (minimum 1), width of the wait counter

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted this cycle when valid&ready
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  transfer address
- cmd_wdata_i  in  DATA_WIDTH  write data
- cmd_strb_i  in  DATA_WIDTH/8  byte strobes (writes only)
- cmd_prot_i  in  3  protection attributes
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_err_o  out  1  pslverr sampled, or timeout
- rsp_timeout_o  out  1  transfer ended by timeout
- paddr_o  out  ADDR_WIDTH  APB address
- pprot_o  out  3  APB protection
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_WIDTH  APB write data
- pstrb_o  out  DATA_WIDTH/8  APB strobes
- pready_i  in  1  slave ready
- prdata_i  in  DATA_WIDTH  slave read data
- pslverr_i  in  1  slave error

Behaviour:
- Reset (rst_i high at a rising edge): FSM goes to IDLE; all outputs 0, including cmd_ready_o, rsp_*, psel_o, penable_o, paddr_o, pwdata_o and pstrb_o; wait counter cleared.
- Reset mid-transfer: the transfer is abandoned and no response is generated; psel_o/penable_o are low the cycle after the reset edge.
- FSM has 4 states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o=1 (combinational from state only; never depends on cmd_valid_i).
  - On valid&ready, all command fields are registered and the FSM moves to SETUP.
- SETUP:
  - Exactly one cycle; psel_o=1, penable_o=0; goes to ACCESS.
  - pstrb_o=cmd_strb for writes and is forced to 0 for reads.
- ACCESS:
  - psel_o=1, penable_o=1; paddr/pwrite/pwdata/pstrb/pprot held stable for the whole transfer.
  - If pready_i=1: capture prdata_i (reads; writes capture 0) and pslverr_i; go to RESP.
  - If pready_i=0: increment the wait counter. When TIMEOUT!=0 and counter==TIMEOUT-1, capture rdata=0, err=1, timeout=1, and go to RESP. pready arriving in that same cycle wins: normal completion, no timeout.
- RESP:
  - psel_o=0, penable_o=0, rsp_valid_o=1, rsp fields stable until rsp_ready_i.
  - On handshake, go to IDLE and clear the counter.
  - No back-to-back overlap: the next command can be accepted no earlier than the cycle after the response handshake.
- Latency (zero-wait slave, rsp_ready_i=1):
  - command accepted at edge N; SETUP in cycle N+1; ACCESS in N+2 with pready high; rsp_valid_o high in N+3; IDLE in N+4.
  - Minimum 4 cycles per transfer.
- Wait states: each cycle of pready_i=0 adds one cycle.
- pslverr_i is sampled only in the ACCESS cycle where pready_i=1; it is ignored otherwise.
- prdata_i is ignored for writes.
- APB outputs other than psel_o/penable_o retain their last values when idle (no forced zero after reset).

Test Plan:
- Write 0x0000_0004 <- 0xDEAD_BEEF, strb 0xF, zero-wait slave -> psel rises 1 cycle after accept, penable 1 cycle later, pwrite=1, pstrb=0xF; rsp_valid at accept+3, rsp_err=0, rsp_rdata=0.
- Read 0x0000_0008, slave returns 0x1234_5678 after 3 wait states -> ACCESS lasts 4 cycles with all APB outputs stable; pstrb=0; rsp_rdata=0x1234_5678, rsp_err=0.
- Write with pslverr_i=1 on the completing cycle -> rsp_err=1, rsp_timeout=0; the next command is accepted normally.
- TIMEOUT=8, slave never asserts pready -> exactly 8 ACCESS cycles, then psel/penable drop; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Separately, pready asserted on the 8th ACCESS cycle -> normal completion, rsp_timeout=0.
- rsp_ready_i held low 5 cycles after a read -> rsp fields stable, cmd_ready_o=0, and a pending cmd_valid_i is not accepted until the cycle after the response handshake.
- rst_i asserted during ACCESS of a write -> next cycle psel=penable=0, rsp_valid=0, cmd_ready=0; cmd_ready_o=1 on the first cycle after rst_i deasserts; a following read completes correctly.

Source files
------------

// File: rtl/apb4_master_bridge_if.sv
// APB4 bus between one initiator and its slaves.
// The master drives the request signals; the slave returns pready, prdata and pslverr.
interface apb4_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr_o;
    logic [2:0]              pprot_o;
    logic                    psel_o;
    logic                    penable_o;
    logic                    pwrite_o;
    logic [DATA_WIDTH-1:0]   pwdata_o;
    logic [DATA_WIDTH/8-1:0] pstrb_o;
    logic                    pready_i;
    logic [DATA_WIDTH-1:0]   prdata_i;
    logic                    pslverr_i;

    modport master (
        output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output pready_i, prdata_i, pslverr_i
    );
endinterface

// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 initiator: one valid/ready command becomes one SETUP/ACCESS
// transfer, and its completion (or a PREADY timeout) comes back on the response stream.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    input  logic [2:0]              cmd_prot_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,

    apb4_master_bridge_if.master    apb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam bit                   TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    wait_cnt_q;
    logic                    expire;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic [2:0]              prot_q;
    logic                    write_q;

    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    timeout_q;

    // NOTE: every output of this block is given a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cmd_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        apb.psel_o    = 1'b0;
        apb.penable_o = 1'b0;
        expire        = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Held low while reset is asserted so nothing is offered to the command stream.
                cmd_ready_o = !rst_i;
                if (cmd_valid_i) state_d = SETUP;
            end
            SETUP: begin
                apb.psel_o = 1'b1;
                state_d    = ACCESS;
            end
            ACCESS: begin
                apb.psel_o    = 1'b1;
                apb.penable_o = 1'b1;
                if (apb.pready_i) begin
                    state_d = RESP;
                end else if (TIMEOUT_EN && wait_cnt_q == CNT_LAST) begin
                    expire  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            prot_q     <= '0;
            write_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && cmd_valid_i) begin
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
                strb_q  <= cmd_write_i ? cmd_strb_i : '0;
                prot_q  <= cmd_prot_i;
                write_q <= cmd_write_i;
            end

            if (state_q == ACCESS) begin
                if (apb.pready_i) begin
                    rdata_q   <= write_q ? '0 : apb.prdata_i;
                    err_q     <= apb.pslverr_i;
                    timeout_q <= 1'b0;
                end else if (expire) begin
                    rdata_q   <= '0;
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end else begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
            end

            if (state_q == RESP && rsp_ready_i) wait_cnt_q <= '0;
        end
    end

    // Request fields come straight from the command registers, so they stay put between transfers.
    assign apb.paddr_o  = addr_q;
    assign apb.pwdata_o = wdata_q;
    assign apb.pstrb_o  = strb_q;
    assign apb.pprot_o  = prot_q;
    assign apb.pwrite_o = write_q;

    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: directed scenarios plus randomized transfers,
// each compared cycle by cycle against expectations derived from the APB4 transfer rules.
module tb_apb4_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            waits;   // pready low cycles before the slave answers
        logic [DW-1:0] rdata;
        logic          slverr;
        int            stall;   // cycles rsp_ready is held low
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    int n_cmp = 0;
    int n_mis = 0;

    apb4_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb4_master_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_strb_i   (cmd_strb),
        .cmd_prot_i   (cmd_prot),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .apb          (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1);
    end

    // Runs one complete transfer starting and ending at a falling edge with the bridge idle.
    task automatic run_xfer(input xfer_t t, input string tag);
        int            n_acc;
        logic [DW-1:0] exp_rdata;
        logic          exp_err, exp_to;
        logic [SW-1:0] exp_strb;
        logic [75:0]   exp_req, act_req;
        logic [37:0]   exp_rsp, act_rsp;
        logic [3:0]    act_idle;

        // Reference outcome: a slave answering within TO cycles completes normally.
        if (t.waits < TO) begin
            n_acc     = t.waits + 1;
            exp_rdata = t.write ? '0 : t.rdata;
            exp_err   = t.slverr;
            exp_to    = 1'b0;
        end else begin
            n_acc     = TO;
            exp_rdata = '0;
            exp_err   = 1'b1;
            exp_to    = 1'b1;
        end
        exp_strb = t.write ? t.strb : '0;

        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_strb  = t.strb;
        cmd_prot  = t.prot;
        cmd_valid = 1'b1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL %s accept: cmd_ready=%b want 1", tag, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;

        exp_req = {1'b1, 1'b0, 1'b0, 1'b0, t.write, t.addr, t.wdata, exp_strb, t.prot};
        act_req = {bus.psel_o, bus.penable_o, rsp_valid, cmd_ready, bus.pwrite_o,
                   bus.paddr_o, bus.pwdata_o, bus.pstrb_o, bus.pprot_o};
        n_cmp++;
        if (act_req !== exp_req) begin
            n_mis++;
            $display("FAIL %s setup: got %h want %h", tag, act_req, exp_req);
        end
        @(negedge clk);

        exp_req[74] = 1'b1;
        for (int a = 0; a < n_acc; a++) begin
            act_req = {bus.psel_o, bus.penable_o, rsp_valid, cmd_ready, bus.pwrite_o,
                       bus.paddr_o, bus.pwdata_o, bus.pstrb_o, bus.pprot_o};
            n_cmp++;
            if (act_req !== exp_req) begin
                n_mis++;
                $display("FAIL %s access[%0d]: got %h want %h", tag, a, act_req, exp_req);
            end
            bus.pready_i  = (a == t.waits);
            bus.prdata_i  = (a == t.waits && !t.write) ? t.rdata : DW'($urandom());
            bus.pslverr_i = (a == t.waits) ? t.slverr : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;

        exp_rsp = {1'b0, 1'b0, 1'b1, 1'b0, exp_rdata, exp_err, exp_to};
        for (int s = 0; s <= t.stall; s++) begin
            act_rsp = {bus.psel_o, bus.penable_o, rsp_valid, cmd_ready, rsp_rdata, rsp_err, rsp_timeout};
            n_cmp++;
            if (act_rsp !== exp_rsp) begin
                n_mis++;
                $display("FAIL %s resp[%0d]: got %h want %h", tag, s, act_rsp, exp_rsp);
            end
            rsp_ready = (s == t.stall);
            cmd_valid = (t.stall > 0);
            @(negedge clk);
        end
        rsp_ready = 1'b0;

        act_idle = {rsp_valid, cmd_ready, bus.psel_o, bus.penable_o};
        n_cmp++;
        if (act_idle !== 4'b0100) begin
            n_mis++;
            $display("FAIL %s idle: got %b want 0100", tag, act_idle);
        end
        cmd_valid = 1'b0;
    endtask

    function automatic xfer_t mk(input logic write, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                                 input int waits, input logic [DW-1:0] rdata,
                                 input logic slverr, input int stall);
        xfer_t t;
        t.write  = write;
        t.addr   = addr;
        t.wdata  = wdata;
        t.strb   = strb;
        t.prot   = 3'($urandom_range(0, 7));
        t.waits  = waits;
        t.rdata  = rdata;
        t.slverr = slverr;
        t.stall  = stall;
        return t;
    endfunction

    task automatic test_reset();
        logic [109:0] act;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        act = {bus.psel_o, bus.penable_o, rsp_valid, cmd_ready, bus.pwrite_o, bus.paddr_o,
               bus.pwdata_o, bus.pstrb_o, bus.pprot_o, rsp_rdata, rsp_err, rsp_timeout};
        n_cmp++;
        if (act !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got %h want 0", act);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_release_ready: cmd_ready=%b want 1", cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_wait_write();
        run_xfer(mk(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 0), "write0");
    endtask

    task automatic test_wait_read();
        run_xfer(mk(1'b0, 32'h0000_0008, 32'h5555_AAAA, 4'hF, 3, 32'h1234_5678, 1'b0, 0), "read3");
    endtask

    task automatic test_slverr();
        run_xfer(mk(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h3, 1, 32'h0, 1'b1, 0), "slverr");
        run_xfer(mk(1'b0, 32'h0000_0014, 32'h0, 4'hF, 0, 32'h0BAD_C0DE, 1'b0, 0), "after_err");
    endtask

    task automatic test_timeout();
        run_xfer(mk(1'b0, 32'h0000_0020, 32'h0, 4'h0, 100, 32'hFFFF_FFFF, 1'b0, 0), "timeout");
        run_xfer(mk(1'b0, 32'h0000_0024, 32'h0, 4'h0, TO - 1, 32'h8765_4321, 1'b0, 0), "ready_last");
    endtask

    task automatic test_rsp_stall();
        run_xfer(mk(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 1'b0, 5), "stall");
    endtask

    task automatic test_reset_mid();
        logic [3:0] act;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h1111_2222;
        cmd_strb  = 4'hF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        act = {bus.psel_o, bus.penable_o, rsp_valid, cmd_ready};
        n_cmp++;
        if (act !== 4'b1100) begin
            n_mis++;
            $display("FAIL rst_mid_access: got %b want 1100", act);
        end
        rst = 1'b1;
        @(negedge clk);
        act = {bus.psel_o, bus.penable_o, rsp_valid, cmd_ready};
        n_cmp++;
        if (act !== 4'b0000) begin
            n_mis++;
            $display("FAIL rst_mid_abort: got %b want 0000", act);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL rst_mid_ready: cmd_ready=%b want 1", cmd_ready);
        end
        @(negedge clk);
        run_xfer(mk(1'b0, 32'h0000_0044, 32'h0, 4'hF, 2, 32'h3C3C_C3C3, 1'b0, 0), "after_rst");
    endtask

    task automatic test_random();
        xfer_t t;
        for (int i = 0; i < 24; i++) begin
            t = mk(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 10), $urandom(), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2));
            run_xfer(t, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        bus.pready_i  = 1'b0;
        bus.prdata_i  = '0;
        bus.pslverr_i = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slverr();
        test_rsp_stall();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
